alu_op_scheduler: RTL and testbench

- Shares one alu_design instance between two requesters using round-robin arbitration.
- Sequences each granted operation: drives opcode, operands and selects; pulses start for multi-cycle ops; waits for done or a timeout; returns result and flags on a response channel.
- Sits between CPU-side command sources and the ALU datapath, one operation in flight at a time.

---
 rtl/alu_op_scheduler.sv | 163 ++++++++++++++++
 tb/tb_alu_op_scheduler.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_scheduler.sv
// Round-robin sharing of one ALU between two requesters.
// One operation in flight: issue, optional multi-cycle wait, respond.
module alu_op_scheduler #(
    parameter int          N       = 16,
    parameter logic [31:0] MC_MASK = 32'h0000_0240,
    parameter int          TIMEOUT = 64
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    output logic         req0_ready,
    input  logic [4:0]   req0_op,
    input  logic [2:0]   req0_sel,
    input  logic [N-1:0] req0_a,
    input  logic [N-1:0] req0_b,
    input  logic         req1_valid,
    output logic         req1_ready,
    input  logic [4:0]   req1_op,
    input  logic [2:0]   req1_sel,
    input  logic [N-1:0] req1_a,
    input  logic [N-1:0] req1_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_result,
    output logic         rsp_sign,
    output logic         rsp_zero,
    output logic         rsp_ovf,
    output logic         rsp_err,
    output logic [4:0]   alu_ctrl,
    output logic [N-1:0] alu_in0,
    output logic [N-1:0] alu_in1,
    output logic [2:0]   alu_sel,
    output logic         alu_start,
    input  logic [N-1:0] alu_out,
    input  logic         alu_sign,
    input  logic         alu_zero,
    input  logic         alu_ovf,
    input  logic         alu_done
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT_MC,
        CAPTURE,
        RESP
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic          ptr;
    logic          cur_id;
    logic [CW-1:0] cnt;

    logic gnt_any;
    logic gnt_sel;
    logic is_mc;
    logic to_hit;
    logic cap_en;
    logic cap_err;

    always_comb begin
        gnt_any = req0_valid | req1_valid;
        // gnt_sel=1 selects req1; the pointer side wins a tie
        gnt_sel = ptr ? req1_valid : ~req0_valid;
        is_mc   = MC_MASK[alu_ctrl];
        to_hit  = (cnt == CW'(TIMEOUT - 1));
        cap_en  = (state == CAPTURE) ||
                  ((state == WAIT_MC) && (alu_done || to_hit));
        cap_err = (state == WAIT_MC) && !alu_done;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        req0_ready = 1'b0;
        req1_ready = 1'b0;
        alu_start  = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state)
            IDLE: begin
                if (rst && gnt_any) begin
                    req0_ready = ~gnt_sel;
                    req1_ready = gnt_sel;
                    state_nxt  = ISSUE;
                end
            end
            ISSUE: begin
                alu_start = is_mc;
                state_nxt = is_mc ? WAIT_MC : CAPTURE;
            end
            WAIT_MC: begin
                if (alu_done || to_hit) begin
                    state_nxt = RESP;
                end
            end
            CAPTURE: begin
                state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr        <= 1'b0;
            cur_id     <= 1'b0;
            cnt        <= '0;
            alu_ctrl   <= '0;
            alu_sel    <= '0;
            alu_in0    <= '0;
            alu_in1    <= '0;
            rsp_id     <= 1'b0;
            rsp_result <= '0;
            rsp_sign   <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_ovf    <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            if (state == IDLE && gnt_any) begin
                alu_ctrl <= gnt_sel ? req1_op : req0_op;
                alu_sel  <= gnt_sel ? req1_sel : req0_sel;
                alu_in0  <= gnt_sel ? req1_a : req0_a;
                alu_in1  <= gnt_sel ? req1_b : req0_b;
                ptr      <= ~gnt_sel;
                cur_id   <= gnt_sel;
            end
            if (state == ISSUE) begin
                cnt <= '0;
            end else if (state == WAIT_MC) begin
                cnt <= cnt + CW'(1);
            end
            // A done seen on the timeout cycle still returns real data
            if (cap_en) begin
                rsp_id     <= cur_id;
                rsp_err    <= cap_err;
                rsp_result <= cap_err ? '0 : alu_out;
                rsp_sign   <= cap_err ? 1'b0 : alu_sign;
                rsp_zero   <= cap_err ? 1'b0 : alu_zero;
                rsp_ovf    <= cap_err ? 1'b0 : alu_ovf;
            end
        end
    end

endmodule

// File: tb/tb_alu_op_scheduler.sv
// Bench for alu_op_scheduler: ALU stub, directed table, corner
// sequences and random traffic against a transaction-level model.
module tb_alu_op_scheduler;

    localparam int N  = 16;
    localparam int TO = 64;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [4:0]   req0_op, req1_op;
    logic [2:0]   req0_sel, req1_sel;
    logic [N-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id;
    logic [N-1:0] rsp_result;
    logic         rsp_sign, rsp_zero, rsp_ovf, rsp_err;
    logic [4:0]   alu_ctrl;
    logic [N-1:0] alu_in0, alu_in1, alu_out;
    logic [2:0]   alu_sel;
    logic         alu_start, alu_sign, alu_zero, alu_ovf, alu_done;

    always #5 clk = ~clk;

    alu_op_scheduler #(
        .N(N), .MC_MASK(32'h0000_0240), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_op(req0_op), .req0_sel(req0_sel),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_op(req1_op), .req1_sel(req1_sel),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_result(rsp_result),
        .rsp_sign(rsp_sign), .rsp_zero(rsp_zero),
        .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
        .alu_ctrl(alu_ctrl), .alu_in0(alu_in0), .alu_in1(alu_in1),
        .alu_sel(alu_sel), .alu_start(alu_start), .alu_out(alu_out),
        .alu_sign(alu_sign), .alu_zero(alu_zero), .alu_ovf(alu_ovf),
        .alu_done(alu_done)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;
    int n_start = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    function automatic logic [N-1:0] alu_fn(input logic [4:0] op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b);
        case (op)
            5'd11:   return a + b;
            5'd5:    return a - b;
            5'd6:    return a * b;
            5'd9:    return a & b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic alu_v(input logic [4:0] op,
                                   input logic [N-1:0] a,
                                   input logic [N-1:0] b,
                                   input logic [N-1:0] r);
        if (op == 5'd11) return (a[N-1] == b[N-1]) && (r[N-1] != a[N-1]);
        if (op == 5'd5)  return (a[N-1] != b[N-1]) && (r[N-1] != a[N-1]);
        return 1'b0;
    endfunction

    function automatic bit is_mc(input logic [4:0] op);
        return (op == 5'd6) || (op == 5'd9);
    endfunction

    // ALU stub: done_delay cycles after start (0 = never), garbage before
    int   done_delay = 0;
    int   mc_cnt = 0;
    logic mc_busy = 1'b0;
    logic [N-1:0] stub_r;

    always @(posedge clk) begin
        if (!rst) begin
            mc_busy <= 1'b0;
            mc_cnt  <= 0;
        end else if (alu_start) begin
            mc_busy <= 1'b1;
            mc_cnt  <= 1;
        end else if (mc_busy) begin
            if (alu_done || mc_cnt >= TO + 2) mc_busy <= 1'b0;
            mc_cnt <= mc_cnt + 1;
        end
    end

    assign alu_done = mc_busy && (done_delay != 0) && (mc_cnt == done_delay);

    always_comb begin
        stub_r = alu_fn(alu_ctrl, alu_in0, alu_in1);
        if (is_mc(alu_ctrl) && !alu_done) stub_r = 16'hDEAD;
    end

    assign alu_out  = stub_r;
    assign alu_sign = stub_r[N-1];
    assign alu_zero = (stub_r == '0);
    assign alu_ovf  = alu_v(alu_ctrl, alu_in0, alu_in1, stub_r);

    // Transaction model: expected response and its cycle, set at grant
    function automatic logic [20:0] exp_rsp(input bit id,
                                            input logic [4:0] op,
                                            input logic [N-1:0] a,
                                            input logic [N-1:0] b,
                                            input int d);
        logic [N-1:0] r;
        if (is_mc(op) && (d == 0 || d > TO)) return {id, 1'b1, 19'd0};
        r = alu_fn(op, a, b);
        return {id, 1'b0, r[N-1], r == '0, alu_v(op, a, b, r), r};
    endfunction

    function automatic int exp_lat(input logic [4:0] op, input int d);
        if (!is_mc(op)) return 3;
        if (d == 0 || d > TO) return TO + 2;
        return d + 2;
    endfunction

    bit           m_busy = 0;
    bit           m_ptr = 0;
    bit           m_mc = 0;
    int           m_gcyc = 0;
    int           m_rcyc = 0;
    logic [39:0]  m_alu = '0;
    logic [20:0]  m_rsp = '0;
    logic         e0, e1;
    bit           g;
    logic [4:0]   g_op;

    always @(negedge clk) begin
        cyc++;
        if (alu_start) n_start++;
        if (!rst) begin
            m_busy = 0;
            m_ptr  = 0;
            chk("rst_ready", 64'({req0_ready, req1_ready}), 64'(0));
        end else begin
            e0 = 1'b0;
            e1 = 1'b0;
            g  = 0;
            if (!m_busy && (req0_valid || req1_valid)) begin
                g  = (req0_valid && req1_valid) ? m_ptr : !req0_valid;
                e0 = !g;
                e1 = g;
            end
            chk("ready", 64'({req0_ready, req1_ready}), 64'({e0, e1}));
            if (m_busy) begin
                chk("start", 64'(alu_start),
                    64'(m_mc && cyc == m_gcyc + 1));
                chk("alu_drive",
                    64'({alu_ctrl, alu_sel, alu_in0, alu_in1}), 64'(m_alu));
                chk("rsp_valid", 64'(rsp_valid), 64'(cyc >= m_rcyc));
                if (rsp_valid && cyc >= m_rcyc) begin
                    chk("rsp", 64'({rsp_id, rsp_err, rsp_sign, rsp_zero,
                                    rsp_ovf, rsp_result}), 64'(m_rsp));
                    if (rsp_ready) m_busy = 0;
                end
            end else begin
                chk("idle_out", 64'({alu_start, rsp_valid}), 64'(0));
            end
            if (e0 || e1) begin
                g_op   = g ? req1_op : req0_op;
                m_mc   = is_mc(g_op);
                m_alu  = g ? {req1_op, req1_sel, req1_a, req1_b}
                           : {req0_op, req0_sel, req0_a, req0_b};
                m_rsp  = g ? exp_rsp(1'b1, g_op, req1_a, req1_b, done_delay)
                           : exp_rsp(1'b0, g_op, req0_a, req0_b, done_delay);
                m_gcyc = cyc;
                m_rcyc = cyc + exp_lat(g_op, done_delay);
                m_ptr  = !g;
                m_busy = 1;
            end
        end
    end

    typedef struct {
        bit           port;
        logic [4:0]   op;
        logic [2:0]   sel;
        logic [N-1:0] a;
        logic [N-1:0] b;
        int           delay;
        logic [N-1:0] r;
        bit           err;
        bit           s;
        bit           z;
        bit           ov;
        int           lat;
    } vec_t;

    vec_t tbl[9];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit p, input logic vld, input logic [4:0] op,
                         input logic [2:0] sel, input logic [N-1:0] a,
                         input logic [N-1:0] b);
        if (p) begin
            req1_valid = vld; req1_op = op; req1_sel = sel;
            req1_a = a; req1_b = b;
        end else begin
            req0_valid = vld; req0_op = op; req0_sel = sel;
            req0_a = a; req0_b = b;
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 300 && m_busy; k++) tick();
        chk("drain", 64'(m_busy), 64'(0));
    endtask

    task automatic wait_ready(input bit p, input string nm);
        bit got = 0;
        for (int k = 0; k < 30 && !got; k++) begin
            @(negedge clk);
            got = p ? req1_ready : req0_ready;
        end
        chk(nm, 64'(got), 64'(1));
    endtask

    task automatic chk_zero(input string nm);
        chk({nm, "_ctl"}, 64'({req0_ready, req1_ready, rsp_valid, rsp_id,
                               rsp_err, rsp_sign, rsp_zero, rsp_ovf,
                               alu_start}), 64'(0));
        chk({nm, "_res"}, 64'(rsp_result), 64'(0));
        chk({nm, "_alu"}, 64'({alu_ctrl, alu_sel, alu_in0, alu_in1}),
            64'(0));
    endtask

    vec_t        tv;
    int          st0, lat, ng, nh, rsel;
    bit          seen;
    logic [3:0]  gseq;
    logic [20:0] snap;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{0, 5'd11, 3'd1, 16'd15, 16'd20, 0, 16'd35, 0, 0, 0, 0, 3};
        tbl[1] = '{1, 5'd6, 3'd2, 16'd8, 16'd2, 5, 16'd16, 0, 0, 0, 0, 7};
        tbl[2] = '{0, 5'd5, 3'd3, 16'd5, 16'd5, 0, 16'd0, 0, 0, 1, 0, 3};
        tbl[3] = '{1, 5'd11, 3'd4, 16'h7fff, 16'd1, 0, 16'h8000,
                   0, 1, 0, 1, 3};
        tbl[4] = '{0, 5'd9, 3'd5, 16'hf0f0, 16'h0ff0, 64, 16'h00f0,
                   0, 0, 0, 0, 66};
        tbl[5] = '{1, 5'd9, 3'd6, 16'd1, 16'd1, 0, 16'd0, 1, 0, 0, 0, 66};
        tbl[6] = '{0, 5'd11, 3'd7, 16'd2, 16'd3, 0, 16'd5, 0, 0, 0, 0, 3};
        tbl[7] = '{1, 5'd6, 3'd0, 16'hfffd, 16'd4, 1, 16'hfff4,
                   0, 1, 0, 0, 3};
        tbl[8] = '{0, 5'd3, 3'd2, 16'h00ff, 16'h0f0f, 0, 16'h0ff0,
                   0, 0, 0, 0, 3};

        rst = 1'b0;
        rsp_ready = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk_zero("reset");

        for (int i = 0; i < 9; i++) begin
            tv = tbl[i];
            tick();
            rsp_ready  = 1'b1;
            done_delay = tv.delay;
            st0        = n_start;
            drive(tv.port, 1, tv.op, tv.sel, tv.a, tv.b);
            wait_ready(tv.port, "tbl_grant");
            tick();
            drive(tv.port, 0, 0, 0, 0, 0);
            lat  = 0;
            seen = 0;
            while (lat < 200 && !seen) begin
                @(negedge clk);
                lat++;
                seen = rsp_valid;
            end
            chk("tbl_lat", 64'(lat), 64'(tv.lat));
            chk("tbl_rsp", 64'({rsp_id, rsp_err, rsp_sign, rsp_zero,
                                rsp_ovf, rsp_result}),
                64'({tv.port, tv.err, tv.s, tv.z, tv.ov, tv.r}));
            tick();
            chk("tbl_starts", 64'(n_start - st0), 64'(is_mc(tv.op) ? 1 : 0));
        end
        drain();

        rst = 1'b0;
        tick();
        rst = 1'b1;
        rsp_ready = 1'b1;
        drive(0, 1, 5, 0, 100, 1);
        drive(1, 1, 5, 0, 200, 2);
        ng   = 0;
        gseq = '0;
        for (int k = 0; k < 200 && ng < 4; k++) begin
            @(negedge clk);
            chk("arb_excl", 64'(req0_ready & req1_ready), 64'(0));
            if (req0_ready || req1_ready) begin
                gseq[3-ng] = req1_ready;
                ng++;
            end
        end
        chk("arb_count", 64'(ng), 64'(4));
        chk("arb_seq", 64'(gseq), 64'(4'b0101));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drain();

        tick();
        rsp_ready  = 1'b0;
        done_delay = 0;
        drive(0, 1, 11, 0, 1, 2);
        wait_ready(0, "bp_grant");
        tick();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 1, 11, 1, 7, 7);
        seen = 0;
        for (int k = 0; k < 20 && !seen; k++) begin
            @(negedge clk);
            seen = rsp_valid;
        end
        snap = {rsp_id, rsp_err, rsp_sign, rsp_zero, rsp_ovf, rsp_result};
        chk("bp_rsp", 64'(snap), 64'({5'b0, 16'd3}));
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_hold", 64'({rsp_valid, rsp_id, rsp_err, rsp_sign,
                                rsp_zero, rsp_ovf, rsp_result}),
                64'({1'b1, snap}));
            chk("bp_ready", 64'({req0_ready, req1_ready}), 64'(0));
        end
        tick();
        rsp_ready = 1'b1;
        drive(1, 0, 0, 0, 0, 0);
        nh = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rsp_valid && rsp_ready) nh++;
        end
        chk("bp_handshakes", 64'(nh), 64'(1));
        drain();

        tick();
        done_delay = 0;
        drive(1, 1, 6, 2, 3, 4);
        wait_ready(1, "rmo_grant");
        tick();
        drive(1, 0, 0, 0, 0, 0);
        repeat (4) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk_zero("rst_midop");
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("rst_norsp", 64'(rsp_valid), 64'(0));
        end
        tick();
        drive(0, 1, 11, 0, 1, 1);
        drive(1, 1, 11, 0, 2, 2);
        @(negedge clk);
        chk("rst_ptr", 64'({req0_ready, req1_ready}), 64'(2'b10));
        tick();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        drain();

        for (int c = 0; c < 1500; c++) begin
            tick();
            if (!m_busy) begin
                rsel = $urandom_range(0, 31);
                if (rsel == 0)      done_delay = 0;
                else if (rsel == 1) done_delay = TO;
                else if (rsel == 2) done_delay = TO + 1;
                else                done_delay = 1 + rsel % 6;
            end
            for (int p = 0; p < 2; p++) begin
                rsel = $urandom_range(0, 5);
                drive(p[0], $urandom_range(0, 2) != 0,
                      rsel == 0 ? 5'd11 : rsel == 1 ? 5'd5 :
                      rsel == 2 ? 5'd6 : rsel == 3 ? 5'd9 :
                      rsel == 4 ? 5'd3 : 5'($urandom),
                      3'($urandom), N'($urandom), N'($urandom));
            end
            rsp_ready = $urandom_range(0, 3) != 0;
        end
        tick();
        drive(0, 0, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0, 0);
        rsp_ready = 1'b1;
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
